pipe_stage_latch: RTL
=====================

Name: pipe_stage_latch

Overview:
- Parametrised, flow-controlled pipeline register for the five-stage core; next generation of the fixed inter-stage latches.
- Carries instruction, PC, PC+4 and two operands with a valid/ready handshake, stall, flush-to-bubble and an optional 2-entry skid buffer.
- Instanced between any two stages (F/D, D/X, X/M, M/W); unused payload fields tie to 0.

Parameters:
- XLEN, 32, width of instruction and operand fields.
- PC_W, 12, width of PC and PC+4 fields.
- NOP, 32'h00000013, instruction emitted on reset and flush (addi x0,x0,0).
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clock  in  1  stage clock; all state updates on the falling edge, as in all existing stage latches.
- reset  in  1  asynchronous, active-low reset; asserts immediately, releases on the falling clock edge.
- flush  in  1  synchronous kill; all held entries become bubbles.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  latch accepts a payload this edge.
- in_insn  in  XLEN  instruction.
- in_pc  in  PC_W  PC.
- in_pc_plus  in  PC_W  PC+4.
- in_a  in  XLEN  operand A.
- in_b  in  XLEN  operand B.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this edge.
- out_insn  out  XLEN  head instruction; NOP when out_valid=0.
- out_pc  out  PC_W  head PC.
- out_pc_plus  out  PC_W  head PC+4.
- out_a  out  XLEN  head operand A.
- out_b  out  XLEN  head operand B.
- count  out  2  entries held (0..2; max 1 when SKID=0).

Behaviour:
- Reset (reset=0), asynchronous: out_valid=0, out_insn=NOP, out_pc/out_pc_plus/out_a/out_b=0, count=0, skid entry invalid. in_ready=1 while reset is held (SKID=1).
- Accept: in_valid & in_ready at the falling edge. Consume: out_valid & out_ready at the falling edge. Latency is one edge, input to out_*.
- SKID=1 state machine, states EMPTY, ONE, TWO (count = 0, 1, 2):
  - EMPTY: accept -> ONE.
  - ONE: accept without consume -> TWO, payload goes to the skid entry; consume without accept -> EMPTY; both -> ONE, head replaced by the new payload.
  - TWO: in_ready=0, no accept. Consume -> ONE, skid entry moves to head.
- SKID=1 in_ready: registered, equal to (state != TWO); never depends combinationally on out_ready.
- SKID=0: in_ready = ~out_valid | out_ready (combinational). Accept loads the head. Consume without accept -> out_valid=0 and out_insn=NOP.
- Stall (out_ready=0 with out_valid=1): all out_* hold bit-exact.
- Ordering: strict FIFO; no payload is dropped or duplicated except by flush.
- Flush at an edge:
  - Result: count=0, out_valid=0, out_insn=NOP, other payload outputs keep their values, in_ready=1.
  - Flush overrides a simultaneous accept (payload dropped) and a simultaneous consume (the consume still counts downstream; the latch only invalidates).
- Invalid head: whenever out_valid=0, out_insn reads NOP so downstream decode sees a bubble.
- Reset mid-operation: all entries lost immediately, no partial update. The first accept after release lands in the head.
- Payload: all fields pass through unmodified; no width conversion or arithmetic.

Test Plan:
- Reset and pass-through: hold reset=0 -> out_valid=0, out_insn=00000013, count=0. Release, then in_valid=1, insn=00A00093, pc=004, pc_plus=008, out_ready=1 -> after one falling edge out_valid=1, out_insn=00A00093, out_pc=004.
- Back-to-back streaming (SKID=1): 8 payloads insn=i, one per edge, out_ready=1 -> outputs in order, count stays 1, in_ready stays 1.
- Skid fill (SKID=1): out_ready=0, send A=00100093 then B=00200093 -> count=2, in_ready=0, out_insn=A. Offer C; raise out_ready -> A then B then C, nothing lost.
- Flush in TWO: with count=2, pulse flush while in_valid=1 -> next edge count=0, out_valid=0, out_insn=00000013, offered payload never appears.
- SKID=0 stall: out_ready=0 with out_valid=1 -> in_ready=0 combinationally, outputs held. out_ready=1 with in_valid=1 -> head replaced the same edge.
- Async reset mid-stall: count=2, drop reset between edges -> outputs clear before the next edge. After release, the first accepted payload appears at the head.

Source files
------------

// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: flow-controlled inter-stage pipeline register.
// Carries instruction, PC, PC+4 and two operands between two stages. It uses a
// valid/ready handshake, supports flush-to-bubble, and can add an optional
// 2-entry skid buffer. All state changes on the falling clock edge, the same
// edge the fixed stage latches it replaces use.
module pipe_stage_latch #(
   parameter int              XLEN = 32,
   parameter int              PC_W = 12,
   parameter logic [XLEN-1:0] NOP  = XLEN'(32'h00000013),
   parameter bit              SKID = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_insn,
   input  logic [PC_W-1:0] in_pc,
   input  logic [PC_W-1:0] in_pc_plus,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_insn,
   output logic [PC_W-1:0] out_pc,
   output logic [PC_W-1:0] out_pc_plus,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [1:0]      count
);

   // One complete stage payload. Head and skid entries share this layout, so
   // moving an entry is a single assignment.
   typedef struct packed {
      logic [XLEN-1:0] insn;
      logic [PC_W-1:0] pc;
      logic [PC_W-1:0] pcPlus;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
   } payload_t;

   // Occupancy states. The encoding is the entry count, so count_q and
   // state_q always move together.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam payload_t RESET_PAYLOAD = '{
      insn:   NOP,
      pc:     '0,
      pcPlus: '0,
      a:      '0,
      b:      '0
   };

   state_t   state_q;
   payload_t head_q;
   payload_t skid_q;
   logic     outValid_q;
   logic     inReady_q;
   logic [1:0] count_q;

   payload_t inPayload;
   logic     accept;
   logic     consume;

   assign inPayload = '{
      insn:   in_insn,
      pc:     in_pc,
      pcPlus: in_pc_plus,
      a:      in_a,
      b:      in_b
   };

   // The skid build registers in_ready so upstream never sees a combinational
   // path from out_ready. The single-entry build must let a consume and an
   // accept happen on the same edge, so its ready looks at out_ready directly.
   // In the single-entry build, ONE -> TWO cannot occur: an accept in ONE
   // requires out_ready, and therefore a consume on the same edge.
   assign in_ready = SKID ? inReady_q : (~outValid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign consume  = outValid_q & out_ready;

   // Occupancy FSM and entry storage. Flush only drops the valid state. The
   // head payload register keeps its value, so the non-instruction outputs
   // remain stable after a flush.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= EMPTY;
         head_q     <= RESET_PAYLOAD;
         skid_q     <= '0;
         outValid_q <= 1'b0;
         inReady_q  <= 1'b1;
         count_q    <= 2'd0;
      end else if (flush) begin
         state_q    <= EMPTY;
         outValid_q <= 1'b0;
         inReady_q  <= 1'b1;
         count_q    <= 2'd0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  head_q     <= inPayload;
                  state_q    <= ONE;
                  outValid_q <= 1'b1;
                  inReady_q  <= 1'b1;
                  count_q    <= 2'd1;
               end
            end
            ONE: begin
               if (accept && !consume) begin
                  skid_q     <= inPayload;
                  state_q    <= TWO;
                  outValid_q <= 1'b1;
                  inReady_q  <= 1'b0;
                  count_q    <= 2'd2;
               end else if (consume && !accept) begin
                  state_q    <= EMPTY;
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  count_q    <= 2'd0;
               end else if (consume && accept) begin
                  head_q     <= inPayload;
               end
            end
            TWO: begin
               if (consume) begin
                  head_q     <= skid_q;
                  state_q    <= ONE;
                  outValid_q <= 1'b1;
                  inReady_q  <= 1'b1;
                  count_q    <= 2'd1;
               end
            end
            default: begin
               state_q    <= EMPTY;
               outValid_q <= 1'b0;
               inReady_q  <= 1'b1;
               count_q    <= 2'd0;
            end
         endcase
      end
   end

   // When the head is not valid, the instruction output shows a bubble, so
   // downstream decode never acts on a stale instruction.
   assign out_valid   = outValid_q;
   assign out_insn    = outValid_q ? head_q.insn : NOP;
   assign out_pc      = head_q.pc;
   assign out_pc_plus = head_q.pcPlus;
   assign out_a       = head_q.a;
   assign out_b       = head_q.b;
   assign count       = count_q;

endmodule
